lfsr_seq_ctrl: RTL and testbench

Sequencer for the team's LFSR module (LFSR_WD, Seed, Enable, OUT_Enable, OUT, Valid, active-low async RST). On a Start request it does four things in order:
- loads a seed by pulsing the LFSR reset;
- steps the LFSR Run_Len times;
- drains LFSR_WD bits serially through OUT_Enable/OUT;
- reassembles those bits into a parallel word, offered on a valid/ready handshake.

It sits between a requesting master and one LFSR instance.

---
 rtl/lfsr_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for one LFSR: seed load, Run_Len steps, serial drain, word reassembly with valid/ready.
// Optional LFSR_SEQ_CTRL_CHAIN_EN adds a Chain input that reseeds from the finished word and restarts.
module lfsr_seq_ctrl #(
  parameter int LFSR_WD = 8,
  parameter int CNT_WD  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [LFSR_WD-1:0] Seed_In,
  input  logic [CNT_WD-1:0]  Run_Len,
`ifdef LFSR_SEQ_CTRL_CHAIN_EN
  input  logic               Chain,
`endif
  output logic               Busy,
  output logic               LFSR_RST_n,
  output logic [LFSR_WD-1:0] LFSR_Seed,
  output logic               LFSR_Enable,
  output logic               LFSR_OUT_Enable,
  input  logic               LFSR_OUT,
  output logic [LFSR_WD-1:0] Word_Out,
  output logic               Word_Valid,
  input  logic               Word_Ready
);

  localparam int IDX_WD = (LFSR_WD > 1) ? $clog2(LFSR_WD) : 1;
  localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(LFSR_WD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    SHIFT,
    DRAIN,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic                pulse_q, pulse_d;     // LOAD phase: 0 = seed settle, 1 = reset pulse
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [CNT_WD-1:0]   run_len_q, run_len_d;
  logic [IDX_WD-1:0]   idx_q, idx_d;
  logic [LFSR_WD-1:0]  seed_d;
  logic                cap_q;                // OUT_Enable delayed to match the LFSR's registered OUT

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    run_len_d = run_len_q;
    idx_d     = idx_q;
    seed_d    = LFSR_Seed;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = LOAD;
          seed_d    = Seed_In;
          run_len_d = Run_Len;
        end
      end
      LOAD: begin
        if (!pulse_q) begin
          pulse_d = 1'b1;
        end else if (run_len_q != '0) begin
          state_d = RUN;
          cnt_d   = run_len_q;
        end else begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_WD'(1)) begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (Word_Ready) begin
          state_d = IDLE;
`ifdef LFSR_SEQ_CTRL_CHAIN_EN
          if (Chain) begin
            state_d = LOAD;
            seed_d  = Word_Out;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pin lines up with the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      pulse_q         <= 1'b0;
      cnt_q           <= '0;
      run_len_q       <= '0;
      idx_q           <= '0;
      cap_q           <= 1'b0;
      Busy            <= 1'b0;
      LFSR_RST_n      <= 1'b0;
      LFSR_Seed       <= '0;
      LFSR_Enable     <= 1'b0;
      LFSR_OUT_Enable <= 1'b0;
      Word_Out        <= '0;
      Word_Valid      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pulse_q         <= pulse_d;
      cnt_q           <= cnt_d;
      run_len_q       <= run_len_d;
      idx_q           <= idx_d;
      LFSR_Seed       <= seed_d;
      Busy            <= (state_d != IDLE);
      LFSR_RST_n      <= !((state_d == LOAD) && pulse_d);
      LFSR_Enable     <= (state_d == RUN);
      LFSR_OUT_Enable <= (state_d == SHIFT);
      cap_q           <= LFSR_OUT_Enable;
      // LSB-first shift-in: after LFSR_WD captures the first drained bit sits in bit 0.
      if (cap_q) Word_Out <= {LFSR_OUT, Word_Out[LFSR_WD-1:1]};
      Word_Valid      <= (state_d == HOLD);
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl with a behavioural LFSR peripheral and word-level reference model.
// Build with +define+LFSR_SEQ_CTRL_CHAIN_EN to also exercise chaining.
module tb_lfsr_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Start = 1'b0;
  logic [W-1:0]  Seed_In = '0;
  logic [CW-1:0] Run_Len = '0;
`ifdef LFSR_SEQ_CTRL_CHAIN_EN
  logic          Chain = 1'b0;
`endif
  logic          Busy, LFSR_RST_n, LFSR_Enable, LFSR_OUT_Enable, Word_Valid;
  logic [W-1:0]  LFSR_Seed, Word_Out;
  logic          LFSR_OUT;
  logic          Word_Ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  lfsr_seq_ctrl #(.LFSR_WD(W), .CNT_WD(CW)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Seed_In(Seed_In), .Run_Len(Run_Len),
`ifdef LFSR_SEQ_CTRL_CHAIN_EN
    .Chain(Chain),
`endif
    .Busy(Busy), .LFSR_RST_n(LFSR_RST_n), .LFSR_Seed(LFSR_Seed), .LFSR_Enable(LFSR_Enable),
    .LFSR_OUT_Enable(LFSR_OUT_Enable), .LFSR_OUT(LFSR_OUT), .Word_Out(Word_Out),
    .Word_Valid(Word_Valid), .Word_Ready(Word_Ready)
  );

  always #5 CLK = ~CLK;

  // One LFSR step; an all-zero state jumps to 8'hAB so a zero seed still advances.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    if (s == '0) return 8'hAB;
    return {s[W-2:0], ^(s & 8'h38)};
  endfunction

  function automatic logic [W-1:0] model_word(input logic [W-1:0] seed, input int steps);
    logic [W-1:0] s;
    s = seed;
    for (int i = 0; i < steps; i++) s = lfsr_step(s);
    return s;
  endfunction

  // Attached LFSR: async active-low load, Enable has priority, OUT_Enable shifts out LSB into a register.
  logic [W-1:0] lfsr_s;
  logic         lfsr_out_r;
  always @(posedge CLK or negedge LFSR_RST_n) begin
    if (!LFSR_RST_n) begin
      lfsr_s     <= LFSR_Seed;
      lfsr_out_r <= 1'b0;
    end else if (LFSR_Enable) begin
      lfsr_s <= lfsr_step(lfsr_s);
    end else if (LFSR_OUT_Enable) begin
      lfsr_out_r <= lfsr_s[0];
      lfsr_s     <= lfsr_s >> 1;
    end
  end
  assign LFSR_OUT = lfsr_out_r;

  // Per-job activity counters sampled on the falling edge.
  int           mon_rst_low, mon_en, mon_oe, mon_overlap, mon_seed_bad;
  logic [W-1:0] mon_seed;
  always @(negedge CLK) begin
    if (!RST && Busy) begin
      if (!LFSR_RST_n) mon_rst_low++;
      if (LFSR_Enable) mon_en++;
      if (LFSR_OUT_Enable) mon_oe++;
      if (LFSR_Enable && LFSR_OUT_Enable) mon_overlap++;
      if (LFSR_Seed !== mon_seed) mon_seed_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input logic [W-1:0] seed);
    mon_rst_low  = 0;
    mon_en       = 0;
    mon_oe       = 0;
    mon_overlap  = 0;
    mon_seed_bad = 0;
    mon_seed     = seed;
  endtask

  // Counts falling edges from the job's start edge until Word_Valid, bounded.
  task automatic wait_valid(input int budget, output int k);
    k = 0;
    while (!Word_Valid && k < budget) begin
      @(negedge CLK);
      k++;
    end
  endtask

  task automatic run_job(input logic [W-1:0] seed, input logic [CW-1:0] len,
                         input int delay, input bit poke);
    logic [W-1:0] exp_w, w0;
    int k, busy_seen;
    exp_w = model_word(seed, int'(len));
    @(negedge CLK);
    Start = 1'b1; Seed_In = seed; Run_Len = len; Word_Ready = (delay == 0);
    clear_mon(seed);
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; Seed_In = W'($urandom); Run_Len = CW'($urandom);
    check("busy_after_start", 32'(Busy), 32'd1);
    check("seed_before_pulse", {LFSR_RST_n, LFSR_Seed}, {1'b1, seed});
    wait_valid(int'(len) + 40, k);
    check("latency", k, int'(len) + 11);
    check("word", 32'(Word_Out), 32'(exp_w));
    w0 = Word_Out;
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        Start = 1'b1; Seed_In = ~seed; Run_Len = 8'd2;
      end
      @(negedge CLK);
      Start = 1'b0;
      check("hold_valid", 32'(Word_Valid), 32'd1);
      check("hold_word", 32'(Word_Out), 32'(w0));
    end
    Word_Ready = 1'b1;
    @(negedge CLK);
    Word_Ready = 1'b0;
    check("valid_drop", 32'(Word_Valid), 32'd0);
    check("busy_drop", 32'(Busy), 32'd0);
    check("rst_pulses", mon_rst_low, 1);
    check("en_cycles", mon_en, int'(len));
    check("oe_cycles", mon_oe, W);
    check("en_oe_overlap", mon_overlap, 0);
    check("seed_stable", mon_seed_bad, 0);
    if (poke) begin
      busy_seen = 0;
      repeat (6) begin
        @(negedge CLK);
        busy_seen += int'(Busy);
      end
      check("no_second_job", busy_seen, 0);
    end
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {Busy, LFSR_RST_n, LFSR_Seed, LFSR_Enable, LFSR_OUT_Enable, Word_Out, Word_Valid},
          '0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_rst_n", {Busy, LFSR_RST_n}, 2'b01);

    run_job(8'hA5, 8'd0, 0, 1'b0);
    run_job(8'h01, 8'd1, 0, 1'b0);
    run_job(8'h00, 8'd1, 1, 1'b0);
    run_job(8'h80, 8'd2, 0, 1'b0);
    run_job(8'h3C, 8'd3, 5, 1'b1);

    // Reset in the middle of RUN.
    @(negedge CLK);
    Start = 1'b1; Seed_In = 8'h5A; Run_Len = 8'd20;
    @(negedge CLK);
    Start = 1'b0;
    repeat (6) @(negedge CLK);
    check("mid_run_enable", 32'(LFSR_Enable), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_run_reset", {Busy, LFSR_RST_n, LFSR_Seed, LFSR_Enable, LFSR_OUT_Enable, Word_Out, Word_Valid},
          '0);
    RST = 1'b0;
    @(negedge CLK);
    run_job(8'h5A, 8'd4, 2, 1'b0);

    for (int j = 0; j < 8; j++) begin
      run_job(W'($urandom), CW'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b0);
    end
    run_job(W'($urandom), 8'd255, 1, 1'b0);

`ifdef LFSR_SEQ_CTRL_CHAIN_EN
    @(negedge CLK);
    Start = 1'b1; Seed_In = 8'h00; Run_Len = 8'd1; Chain = 1'b1; Word_Ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    wait_valid(60, k);
    check("chain_latency1", k, 12);
    check("chain_word1", 32'(Word_Out), 32'h0000_00AB);
    @(negedge CLK);
    Chain = 1'b0;
    check("chain_busy", {Busy, Word_Valid}, 2'b10);
    check("chain_seed", 32'(LFSR_Seed), 32'h0000_00AB);
    wait_valid(60, k);
    check("chain_latency2", k, 12);
    check("chain_word2", 32'(Word_Out), 32'(model_word(8'hAB, 1)));
    @(negedge CLK);
    Word_Ready = 1'b0;
    check("chain_end", {Busy, Word_Valid}, 2'b00);
`endif

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
